alu_cmd_driver: RTL and testbench
=================================

# alu_cmd_driver

Sequential command front-end that drives the combinational 4-bit ALU. It accepts opcode/operand commands over a valid/ready handshake, buffers them in a small FIFO, and issues each one to the ALU with the internal accumulator as operand A. It captures the ALU result back into the accumulator and returns the result with status flags over a second valid/ready handshake. It is the initiator side of the ALU's operand/select/result interface.

## Interface
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_load  input  1  1 = load accumulator with cmd_b, no ALU op.
- cmd_op  input  3  ALU select: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 nand, 111 nor.
- cmd_b  input  4  operand B, or load value.
- alu_a  output  4  registered operand A to ALU.
- alu_b  output  4  registered operand B to ALU.
- alu_sel  output  3  registered select to ALU.
- alu_out  input  4  ALU result.
- alu_carry  input  1  ALU carry; bit 4 of A+B regardless of select.
- res_valid  output  1  result present.
- res_ready  input  1  consumer accepts result.
- res_data  output  4  result / new accumulator value.
- res_carry  output  1  alu_carry if op==000 and not load, else 0.
- res_zero  output  1  res_data==0.
- res_dz  output  1  op==011 and operand B==0, not load.
- acc  output  4  current accumulator.

## Operation
- Command handshake: transfer when cmd_valid && cmd_ready at a rising edge. The FIFO stores {load, op, b} in order.
- cmd_ready depends on the current full flag only. A pop in the same cycle does not open a slot that cycle.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if the FIFO is non-empty, pop the head, register alu_a=acc, alu_b=b, alu_sel=op, and go to ISSUE. Otherwise stay.
  - ISSUE: the ALU settles combinationally.
    - At the end of the cycle, for an ALU op: acc, res_data ← alu_out.
    - For a load: acc, res_data ← b.
    - Latch the flags. Set res_valid. Go to RESP.
  - RESP: hold res_* stable. On res_valid && res_ready, clear res_valid and go to IDLE.
- Loads still pass through ISSUE. alu_a/alu_b/alu_sel are loaded but alu_out is ignored.
- Arithmetic is 4-bit modulo 16, exactly as the ALU returns it. Examples: 9+9 → 2 with carry 1; 2−5 → 13; 6×3 → 2; x/0 → 0 with res_dz=1.
- alu_a/alu_b/alu_sel hold their last values outside ISSUE.
- Results return in command order. There is never more than one command in flight.

## Timing
- Reset (rst_n low, asynchronous):
  - State IDLE, FIFO empty.
  - acc, alu_a, alu_b, alu_sel, res_data = 0.
  - res_valid, res_carry, res_dz = 0; res_zero = 1.
  - cmd_ready = 1.
  - Commands presented during reset are dropped.
- Reset mid-operation: the FIFO contents and the in-flight command are discarded, no result is produced, and the block restarts in IDLE after rst_n rises.
- Latency with FIFO empty and res_ready high:
  - Command accepted at edge ending cycle 0.
  - Pop in cycle 1 (IDLE).
  - ISSUE in cycle 2.
  - res_valid high in cycle 3.
  - Back to IDLE in cycle 4.
- Throughput: one command per 3 cycles when back-to-back.
- Backpressure: with res_ready low, the block stalls in RESP indefinitely and the FIFO fills. cmd_ready drops after FIFO_DEPTH further accepts.
- Simultaneous push and pop in IDLE: both occur and the count is unchanged.
- Full FIFO: push is ignored (cmd_ready = 0).
- Empty FIFO: IDLE holds.

## Test plan
- Reset, load 5, add 3 → res_data=8, carry=0, zero=0, acc=8; res_valid rises 3 cycles after add accept.
- Load 9, add 9 → res_data=2, res_carry=1. Then sub 2 → res_data=0, res_zero=1, res_carry=0.
- Load 7, div 0 → res_data=0, res_dz=1, acc=0. Load 2, sub 5 → 13. Load 6, mul 3 → 2.
- Hold res_ready low, push 8 commands back-to-back:
  - 5 are accepted (1 in flight plus 4 in the FIFO) and cmd_ready=0 on the 6th.
  - Release res_ready → all results return in order with no loss.
- Logic ops: load 4'hC, then and 4'hA → 8, or 4'h1 → 9, nand 4'hF → 6, nor 4'h0 → 9; carry=0 on all.
- Assert rst_n low during ISSUE with 3 commands queued → no res_valid, acc=0, cmd_ready=1. A post-reset add 1 returns 1.

Source files
------------

// File: rtl/alu_cmd_driver_if.sv
// Signal bundle between alu_cmd_driver and its environment.
// It carries the command stream, the result stream and the ALU operand/select/result lines.
interface alu_cmd_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [3:0] cmd_b;

    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_out;
    logic       alu_carry;

    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_carry;
    logic       res_zero;
    logic       res_dz;

    logic [3:0] acc;

    // master: command source, result consumer and the combinational ALU
    modport master (
        output cmd_valid, cmd_load, cmd_op, cmd_b, res_ready, alu_out, alu_carry,
        input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data,
               res_carry, res_zero, res_dz, acc
    );

    // slave: the command driver itself
    modport slave (
        input  cmd_valid, cmd_load, cmd_op, cmd_b, res_ready, alu_out, alu_carry,
        output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data,
               res_carry, res_zero, res_dz, acc
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// Command front-end for the 4-bit combinational ALU: buffers commands in a FIFO,
// issues them one at a time with the accumulator as operand A, and returns results.
module alu_cmd_driver #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_cmd_driver_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          capture;
    logic          release_res;
    logic [7:0]    head;

    logic       cur_load;
    logic [3:0] acc_q;
    logic [3:0] alu_a_q;
    logic [3:0] alu_b_q;
    logic [2:0] alu_sel_q;
    logic [3:0] res_data_q;
    logic       res_valid_q;
    logic       res_carry_q;
    logic       res_dz_q;
    logic [3:0] capture_value;

    // Ready looks only at the registered full flag, so a same-cycle pop never frees a slot early.
    assign full          = (count == CNT_FULL);
    assign empty         = (count == '0);
    assign push          = bus.cmd_valid && !full;
    assign head          = fifo_mem[rd_ptr];
    assign bus.cmd_ready = !full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.cmd_load, bus.cmd_op, bus.cmd_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                capture    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    release_res = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A load still travels through ISSUE, but the ALU result is replaced by the load value.
    always_comb begin
        capture_value = cur_load ? alu_b_q : bus.alu_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_load    <= 1'b0;
            acc_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_carry_q <= 1'b0;
            res_dz_q    <= 1'b0;
        end else begin
            if (pop) begin
                alu_a_q   <= acc_q;
                alu_b_q   <= head[3:0];
                alu_sel_q <= head[6:4];
                cur_load  <= head[7];
            end
            if (capture) begin
                acc_q       <= capture_value;
                res_data_q  <= capture_value;
                res_carry_q <= !cur_load && (alu_sel_q == 3'b000) && bus.alu_carry;
                res_dz_q    <= !cur_load && (alu_sel_q == 3'b011) && (alu_b_q == 4'd0);
                res_valid_q <= 1'b1;
            end else if (release_res) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.acc       = acc_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_carry = res_carry_q;
    assign bus.res_zero  = (res_data_q == 4'd0);
    assign bus.res_dz    = res_dz_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: a behavioural ALU stub plus an in-order
// result model computed from the command stream, exercised by directed and random steps.
module tb_alu_cmd_driver;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_cmd_driver_if bus ();

    alu_cmd_driver #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] data;
        logic       carry;
        logic       dz;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] model_acc = 4'd0;

    function automatic logic [3:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia;
        int ib;
        int r;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0:    r = ia + ib;
            3'd1:    r = ia - ib;
            3'd2:    r = ia * ib;
            3'd3:    r = (ib == 0) ? 0 : ia / ib;
            3'd4:    r = ia & ib;
            3'd5:    r = ia | ib;
            3'd6:    r = ~(ia & ib);
            default: r = ~(ia | ib);
        endcase
        return r[3:0];
    endfunction

    // Behavioural stand-in for the combinational ALU
    logic [4:0] alu_sum;
    assign alu_sum       = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    assign bus.alu_carry = alu_sum[4];
    assign bus.alu_out   = alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b);

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_accept(input logic ld, input logic [2:0] op, input logic [3:0] b);
        exp_t e;
        int   s;
        e.a   = model_acc;
        e.b   = b;
        e.sel = op;
        if (ld) begin
            e.data  = b;
            e.carry = 1'b0;
            e.dz    = 1'b0;
        end else begin
            s       = int'(model_acc) + int'(b);
            e.data  = alu_fn(op, model_acc, b);
            e.carry = (op == 3'd0) && (s >= 16);
            e.dz    = (op == 3'd3) && (b == 4'd0);
        end
        model_acc = e.data;
        exp_q.push_back(e);
    endfunction

    task automatic apply_stimulus(input logic ld, input logic [2:0] op, input logic [3:0] b);
        int n;
        n = 0;
        bus.cmd_load  = ld;
        bus.cmd_op    = op;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("cmd_accept_timeout", {7'd0, bus.cmd_ready}, 8'd1);
        if (bus.cmd_ready) begin
            model_accept(ld, op, b);
            @(posedge clk);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic get_result(output int waited);
        exp_t e;
        waited = 0;
        while (!bus.res_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_output("res_valid_timeout", {7'd0, bus.res_valid}, 8'd1);
        check_output("queue_nonempty", {7'd0, exp_q.size() != 0}, 8'd1);
        if (bus.res_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_output("res_data",  {4'd0, bus.res_data}, {4'd0, e.data});
            check_output("res_carry", {7'd0, bus.res_carry}, {7'd0, e.carry});
            check_output("res_dz",    {7'd0, bus.res_dz}, {7'd0, e.dz});
            check_output("res_zero",  {7'd0, bus.res_zero}, {7'd0, e.data == 4'd0});
            check_output("acc",       {4'd0, bus.acc}, {4'd0, e.data});
            check_output("alu_a",     {4'd0, bus.alu_a}, {4'd0, e.a});
            check_output("alu_b",     {4'd0, bus.alu_b}, {4'd0, e.b});
            check_output("alu_sel",   {5'd0, bus.alu_sel}, {5'd0, e.sel});
            bus.res_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.res_ready = 1'b0;
            check_output("res_valid_cleared", {7'd0, bus.res_valid}, 8'd0);
        end
    endtask

    task automatic burst(input int n, output int accepted, output logic ready_at_6);
        logic       ld;
        logic [2:0] op;
        logic [3:0] b;
        accepted   = 0;
        ready_at_6 = 1'b1;
        for (int i = 0; i < n; i++) begin
            ld            = ($urandom_range(0, 3) == 0);
            op            = 3'($urandom_range(0, 7));
            b             = 4'($urandom_range(0, 15));
            bus.cmd_load  = ld;
            bus.cmd_op    = op;
            bus.cmd_b     = b;
            bus.cmd_valid = 1'b1;
            if (i == 5) begin
                ready_at_6 = bus.cmd_ready;
            end
            if (bus.cmd_ready) begin
                model_accept(ld, op, b);
                accepted++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   waited;
        int   accepted;
        logic ready6;

        bus.cmd_valid = 1'b1;
        bus.cmd_load  = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_b     = 4'd7;
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
        check_output("rst_res_valid", {7'd0, bus.res_valid}, 8'd0);
        check_output("rst_acc",       {4'd0, bus.acc}, 8'd0);
        check_output("rst_alu_a",     {4'd0, bus.alu_a}, 8'd0);
        check_output("rst_alu_b",     {4'd0, bus.alu_b}, 8'd0);
        check_output("rst_alu_sel",   {5'd0, bus.alu_sel}, 8'd0);
        check_output("rst_res_data",  {4'd0, bus.res_data}, 8'd0);
        check_output("rst_res_zero",  {7'd0, bus.res_zero}, 8'd1);
        check_output("rst_res_carry", {7'd0, bus.res_carry}, 8'd0);
        check_output("rst_res_dz",    {7'd0, bus.res_dz}, 8'd0);
        bus.cmd_valid = 1'b0;
        rst_n         = 1'b1;
        repeat (5) @(negedge clk);
        check_output("no_result_from_reset_cmd", {7'd0, bus.res_valid}, 8'd0);

        $display("[TB] basic add and latency");
        apply_stimulus(1'b1, 3'd0, 4'd5);
        get_result(waited);
        apply_stimulus(1'b0, 3'd0, 4'd3);
        get_result(waited);
        check_output("add_latency", 8'(waited), 8'd2);
        check_output("add_5_3", {4'd0, bus.acc}, 8'd8);

        $display("[TB] carry and zero");
        apply_stimulus(1'b1, 3'd0, 4'd9);
        get_result(waited);
        apply_stimulus(1'b0, 3'd0, 4'd9);
        get_result(waited);
        check_output("add_9_9", {4'd0, bus.res_data}, 8'd2);
        check_output("add_9_9_carry", {7'd0, bus.res_carry}, 8'd1);
        apply_stimulus(1'b0, 3'd1, 4'd2);
        get_result(waited);
        check_output("sub_zero", {7'd0, bus.res_zero}, 8'd1);

        $display("[TB] div by zero, sub wrap, mul wrap");
        apply_stimulus(1'b1, 3'd0, 4'd7);
        get_result(waited);
        apply_stimulus(1'b0, 3'd3, 4'd0);
        get_result(waited);
        check_output("div0_dz", {7'd0, bus.res_dz}, 8'd1);
        check_output("div0_acc", {4'd0, bus.acc}, 8'd0);
        apply_stimulus(1'b1, 3'd0, 4'd2);
        get_result(waited);
        apply_stimulus(1'b0, 3'd1, 4'd5);
        get_result(waited);
        check_output("sub_2_5", {4'd0, bus.res_data}, 8'd13);
        apply_stimulus(1'b1, 3'd0, 4'd6);
        get_result(waited);
        apply_stimulus(1'b0, 3'd2, 4'd3);
        get_result(waited);
        check_output("mul_6_3", {4'd0, bus.res_data}, 8'd2);

        $display("[TB] logic ops");
        apply_stimulus(1'b1, 3'd0, 4'hC);
        get_result(waited);
        apply_stimulus(1'b0, 3'd4, 4'hA);
        get_result(waited);
        check_output("and_C_A", {4'd0, bus.acc}, 8'd8);
        apply_stimulus(1'b0, 3'd5, 4'h1);
        get_result(waited);
        check_output("or_8_1", {4'd0, bus.acc}, 8'd9);
        apply_stimulus(1'b0, 3'd6, 4'hF);
        get_result(waited);
        check_output("nand_9_F", {4'd0, bus.acc}, 8'd6);
        apply_stimulus(1'b0, 3'd7, 4'h0);
        get_result(waited);
        check_output("nor_6_0", {4'd0, bus.acc}, 8'd9);

        $display("[TB] backpressure");
        burst(8, accepted, ready6);
        check_output("burst_accepted", 8'(accepted), 8'd5);
        check_output("ready_on_6th", {7'd0, ready6}, 8'd0);
        for (int i = 0; i < accepted; i++) begin
            get_result(waited);
        end
        check_output("burst_drained", 8'(exp_q.size()), 8'd0);

        $display("[TB] random commands");
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            get_result(waited);
        end
        for (int r = 0; r < 4; r++) begin
            burst($urandom_range(1, 7), accepted, ready6);
            for (int i = 0; i < accepted; i++) begin
                get_result(waited);
            end
        end

        $display("[TB] reset during ISSUE");
        apply_stimulus(1'b1, 3'd0, 4'd4);
        burst(4, accepted, ready6);
        check_output("prefill_accepted", 8'(accepted), 8'd4);
        get_result(waited);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = 1'b1;
        bus.cmd_b     = 4'd3;
        #1;
        check_output("midrst_res_valid", {7'd0, bus.res_valid}, 8'd0);
        check_output("midrst_acc", {4'd0, bus.acc}, 8'd0);
        check_output("midrst_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
        repeat (3) @(negedge clk);
        rst_n         = 1'b1;
        bus.cmd_valid = 1'b0;
        exp_q.delete();
        model_acc = 4'd0;
        repeat (6) @(negedge clk);
        check_output("postrst_no_result", {7'd0, bus.res_valid}, 8'd0);
        check_output("postrst_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
        apply_stimulus(1'b0, 3'd0, 4'd1);
        get_result(waited);
        check_output("postrst_add_1", {4'd0, bus.res_data}, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
